// File: rtl/scan_frame_pkg.sv
// Shared types and constants for the scan-frame scanner: FSM states, mode codes
// and the counter-width helper used by the bit timer.
package scan_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_CAPTURE = 2'b00;
  localparam logic [1:0] MODE_LOAD    = 2'b01;
  localparam logic [1:0] MODE_XCHG    = 2'b10;

  // Width for a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_frame_scanner_if.sv
// Controller-facing bus of the scan-frame scanner; the master is the frame-level
// test controller, the slave is the scanner itself.
interface scan_frame_scanner_if
  import scan_frame_pkg::*;
#(
    parameter int NUM_CH = 8
);
    // Handshake: START is a request sampled only while the scanner is idle; a
    // request seen in any other state is dropped, not queued. BUSY is high from
    // the cycle after acceptance through the last serial bit, and DONE pulses for
    // exactly one cycle after BUSY falls, with CFG already holding the commit.
    logic [NUM_CH-1:0] INPUT;
    logic              START;
    logic [1:0]        MODE;
    logic              D;
    logic              OUTPUT;
    logic              OUT_VALID;
    logic [NUM_CH-1:0] CFG;
    logic              BUSY;
    logic              DONE;
    state_t            dbg_state;
    logic [1:0]        dbg_mode;

    modport master (
        output INPUT, START, MODE, D,
        input  OUTPUT, OUT_VALID, CFG, BUSY, DONE, dbg_state, dbg_mode
    );

    modport slave (
        input  INPUT, START, MODE, D,
        output OUTPUT, OUT_VALID, CFG, BUSY, DONE, dbg_state, dbg_mode
    );

endinterface

// File: rtl/scan_bit_timer.sv
// Bit-period divider plus bit counter: strobes once per DIV cycles while enabled
// and flags the strobe that completes the NUM_CH-th bit.
module scan_bit_timer
  import scan_frame_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DIV    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic strobe,
    output logic last_bit
);

    localparam int DW = cnt_width(DIV);
    localparam int BW = cnt_width(NUM_CH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NUM_CH - 1);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;

    assign strobe   = en && (div_cnt == DIV_LAST);
    assign last_bit = strobe && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (strobe) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
        end else if (en) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scan_frame_scanner.sv
// NUM_CH-channel vertical scanner: captures island outputs and/or loads a config
// word over one serial pad per transaction, committing CFG atomically at the end.
module scan_frame_scanner
  import scan_frame_pkg::*;
#(
    parameter int                NUM_CH    = 8,
    parameter int                DIV       = 2,
    parameter logic [NUM_CH-1:0] CFG_RESET = '0
) (
    input logic                  CLK1,
    input logic                  RESET,
    scan_frame_scanner_if.slave  bus
);

    state_t            state;
    logic [1:0]        mode_q;
    logic [NUM_CH-1:0] sreg;
    logic [NUM_CH-1:0] sreg_next;
    logic [NUM_CH-1:0] cfg_q;
    logic              busy_q;
    logic              done_q;
    logic              strobe;
    logic              last_bit;
    logic              din;

    scan_bit_timer #(
        .NUM_CH (NUM_CH),
        .DIV    (DIV)
    ) u_timer (
        .clk      (CLK1),
        .rst      (RESET),
        .clear    (state == CAPTURE),
        .en       (state == SHIFT),
        .strobe   (strobe),
        .last_bit (last_bit)
    );

    // Capture-only transactions shift zeros in so the pad never feeds CFG.
    assign din       = (mode_q != MODE_CAPTURE) && bus.D;
    assign sreg_next = {din, sreg[NUM_CH-1:1]};

    always_ff @(posedge CLK1) begin
        if (RESET) begin
            state  <= IDLE;
            mode_q <= MODE_CAPTURE;
            sreg   <= '0;
            cfg_q  <= CFG_RESET;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        // Reserved code 11 behaves as a plain capture.
                        mode_q <= (bus.MODE == MODE_LOAD || bus.MODE == MODE_XCHG) ?
                                  bus.MODE : MODE_CAPTURE;
                        busy_q <= 1'b1;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    sreg  <= (mode_q == MODE_LOAD) ? '0 : bus.INPUT;
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (strobe) begin
                        sreg <= sreg_next;
                    end
                    if (last_bit) begin
                        if (mode_q != MODE_CAPTURE) begin
                            cfg_q <= sreg_next;
                        end
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FINISH;
                    end
                end
                FINISH: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.OUTPUT    = (state == SHIFT) && sreg[0];
    assign bus.OUT_VALID = strobe;
    assign bus.CFG       = cfg_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.dbg_state = state;
    assign bus.dbg_mode  = mode_q;

endmodule

// File: tb/tb_scan_frame_scanner.sv
// Directed bench for scan_frame_scanner: a DIV=2 instance (a) and a DIV=1
// instance (b), both NUM_CH=8 with CFG_RESET=8'hA5, checked cycle by cycle.
module tb_scan_frame_scanner;
  import scan_frame_pkg::*;

  logic clk;
  logic rst;
  int total = 0;
  int bad = 0;
  logic exp_q[$];

  scan_frame_scanner_if #(.NUM_CH(8)) ifa ();
  scan_frame_scanner_if #(.NUM_CH(8)) ifb ();

  scan_frame_scanner #(.NUM_CH(8), .DIV(2), .CFG_RESET(8'hA5)) dut_a (
    .CLK1(clk), .RESET(rst), .bus(ifa.slave)
  );
  scan_frame_scanner #(.NUM_CH(8), .DIV(1), .CFG_RESET(8'hA5)) dut_b (
    .CLK1(clk), .RESET(rst), .bus(ifb.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input bit sel, input logic start, input logic [1:0] mode,
                       input logic [7:0] in_w, input logic d);
    if (sel) begin
      ifb.START = start; ifb.MODE = mode; ifb.INPUT = in_w; ifb.D = d;
    end else begin
      ifa.START = start; ifa.MODE = mode; ifa.INPUT = in_w; ifa.D = d;
    end
  endtask

  task automatic sample(input bit sel, output logic o, output logic v, output logic b,
                        output logic dn, output logic [7:0] c);
    if (sel) begin
      o = ifb.OUTPUT; v = ifb.OUT_VALID; b = ifb.BUSY; dn = ifb.DONE; c = ifb.CFG;
    end else begin
      o = ifa.OUTPUT; v = ifa.OUT_VALID; b = ifa.BUSY; dn = ifa.DONE; c = ifa.CFG;
    end
  endtask

  // One full transaction, START accepted at cycle t; cycle t+n is sampled at
  // the n-th negedge afterwards and compared with the timing model.
  task automatic txn(input bit sel, input logic [1:0] mode, input logic [7:0] in_w,
                     input logic [7:0] d_w, input logic [7:0] old_cfg,
                     input logic [7:0] exp_cfg, input bit poke, input string name);
    int div;
    int last;
    int done_n;
    int k;
    bit in_shift;
    bit strobe_exp;
    logic [7:0] exp_out;
    logic o, v, b, dn, d;
    logic [7:0] c;
    logic [1:0] m;
    logic s;
    logic q;
    div = sel ? 1 : 2;
    last = 1 + 8 * div;
    done_n = last + 1;
    exp_out = (mode == MODE_LOAD) ? 8'h00 : in_w;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_out[i]);
    @(negedge clk);
    drive(sel, 1'b1, mode, in_w, 1'b0);
    for (int n = 1; n <= done_n + 1; n++) begin
      @(negedge clk);
      sample(sel, o, v, b, dn, c);
      in_shift = (n >= 2) && (n <= last);
      k = in_shift ? (n - 2) / div : 0;
      strobe_exp = in_shift && ((n - 2) % div == div - 1);
      check($sformatf("%s_busy_c%0d", name, n), {31'd0, b}, {31'd0, (n >= 1 && n <= last)});
      check($sformatf("%s_out_c%0d", name, n), {31'd0, o}, {31'd0, in_shift ? exp_out[k] : 1'b0});
      check($sformatf("%s_ovalid_c%0d", name, n), {31'd0, v}, {31'd0, strobe_exp});
      check($sformatf("%s_done_c%0d", name, n), {31'd0, dn}, {31'd0, n == done_n});
      check($sformatf("%s_cfg_c%0d", name, n), {24'd0, c}, {24'd0, (n < done_n) ? old_cfg : exp_cfg});
      if (v) begin
        q = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        check($sformatf("%s_sb_bit", name), {31'd0, o}, {31'd0, q});
      end
      // D carries the next word bit on strobe cycles and noise elsewhere.
      d = strobe_exp ? d_w[k] : 1'($urandom_range(0, 1));
      s = poke && (n == 5 || n == done_n);
      m = s ? ~mode : mode;
      drive(sel, s, m, (n >= 2) ? 8'($urandom) : in_w, d);
    end
    check($sformatf("%s_sb_left", name), exp_q.size(), 32'd0);
    drive(sel, 1'b0, mode, in_w, 1'b0);
  endtask

  initial begin
    logic o, v, b, dn;
    logic [7:0] c;
    int seen;
    logic [7:0] ab_w;
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sample(1'b0, o, v, b, dn, c);
    check("rst_cfg", {24'd0, c}, 32'hA5);
    check("rst_out", {31'd0, o}, 32'd0);
    check("rst_busy", {31'd0, b}, 32'd0);
    check("rst_done", {31'd0, dn}, 32'd0);
    check("rst_ovalid", {31'd0, v}, 32'd0);
    check("rst_state", 32'(ifa.dbg_state), 32'(IDLE));
    check("rst_cfg_b", {24'd0, ifb.CFG}, 32'hA5);

    txn(1'b0, MODE_CAPTURE, 8'b1100_1010, 8'hFF, 8'hA5, 8'hA5, 1'b0, "capture");
    txn(1'b0, MODE_LOAD, 8'h5E, 8'h81, 8'hA5, 8'h81, 1'b0, "load");
    txn(1'b1, MODE_XCHG, 8'hF0, 8'h3C, 8'hA5, 8'h3C, 1'b0, "xchg_div1");
    txn(1'b1, 2'b11, 8'h69, 8'hFF, 8'h3C, 8'h3C, 1'b0, "mode11");

    txn(1'b0, MODE_XCHG, 8'h33, 8'h96, 8'h81, 8'h96, 1'b1, "ignored_start");
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check($sformatf("post_ignore_busy_%0d", n), {31'd0, ifa.BUSY}, 32'd0);
      check($sformatf("post_ignore_done_%0d", n), {31'd0, ifa.DONE}, 32'd0);
    end
    check("post_ignore_mode", {30'd0, ifa.dbg_mode}, {30'd0, MODE_XCHG});
    check("post_ignore_state", 32'(ifa.dbg_state), 32'(IDLE));

    // abort a load after three bits have shifted
    ab_w = 8'h5A;
    seen = 0;
    @(negedge clk);
    drive(1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      ifa.START = 1'b0;
      if (ifa.OUT_VALID) begin
        ifa.D = ab_w[seen];
        seen++;
      end
      if (seen == 3) break;
    end
    check("abort_bits_seen", seen, 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", 32'(ifa.dbg_state), 32'(IDLE));
    check("abort_cfg", {24'd0, ifa.CFG}, 32'hA5);
    check("abort_busy", {31'd0, ifa.BUSY}, 32'd0);
    check("abort_out", {31'd0, ifa.OUTPUT}, 32'd0);
    check("abort_mode", {30'd0, ifa.dbg_mode}, 32'd0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check($sformatf("abort_nodone_%0d", n), {31'd0, ifa.DONE}, 32'd0);
    end
    txn(1'b0, MODE_LOAD, 8'h00, 8'h0F, 8'hA5, 8'h0F, 1'b0, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_frame_scanner.md
Name: scan_frame_scanner

Overview:
- Parametrised successor to the fixed 4-input vertical scanner cell that sits between analog islands and the pad frame.
- Generalised to NUM_CH channels with a programmable bit-period divider.
- Has three modes, selected per transaction:
  - capture-and-shift-out (read island digital outputs over one pad);
  - shift-in-and-commit (load a parallel config word from one pad);
  - exchange (both at once).
- Owns the START/BUSY/DONE handshake toward the frame-level test controller.

Parameters:
- NUM_CH, 8, number of parallel channels and shift-register length (>=2).
- DIV, 2, clock cycles per serial bit (>=1; 1 means one bit per cycle).
- CFG_RESET, 0, reset value of CFG (NUM_CH bits).

Ports:
- CLK1  in  1  sole clock; all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- INPUT  in  NUM_CH  parallel channel inputs, sampled in CAPTURE.
- START  in  1  transaction request; honoured only in IDLE.
- MODE  in  2  00 capture-out, 01 load, 10 exchange, 11 treated as 00; latched on accepted START.
- D  in  1  serial data in, sampled on strobe cycles.
- OUTPUT  out  1  serial data out, LSB (channel 0) first.
- OUT_VALID  out  1  strobe: high on the last cycle of each bit period in SHIFT.
- CFG  out  NUM_CH  committed parallel configuration word.
- BUSY  out  1  high in CAPTURE and SHIFT.
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs are held while RESET=1; they take these values from the first cycle after release.
  - State=IDLE.
  - Shift register, counters and latched mode = 0.
  - OUTPUT=0, OUT_VALID=0, BUSY=0, DONE=0, CFG=CFG_RESET.
- RESET mid-transaction aborts immediately. CFG reverts to CFG_RESET and no DONE pulse is issued.
- FSM states: IDLE, CAPTURE, SHIFT, FINISH.
- IDLE:
  - START=1 latches MODE and moves to CAPTURE next cycle.
  - START is ignored in every other state; it is never queued.
- CAPTURE (1 cycle):
  - MODE 00/10: shift register <= INPUT.
  - MODE 01: shift register <= 0.
  - Clears the divider and bit counter; next state is SHIFT.
- SHIFT:
  - div_cnt counts 0..DIV-1; the strobe is div_cnt==DIV-1.
  - OUTPUT = sreg[0] throughout SHIFT; 0 in all other states.
  - On strobe: OUT_VALID=1, sreg <= {din, sreg[NUM_CH-1:1]}. din = D in MODE 01/10, 0 in MODE 00. bit_cnt increments.
  - After the NUM_CH-th strobe, next state is FINISH.
- FINISH (1 cycle):
  - DONE=1, BUSY=0.
  - CFG updates on the edge entering FINISH (visible together with DONE). It takes the final shift-register contents in MODE 01/10 and is unchanged in MODE 00.
  - Next state is IDLE. START during FINISH is ignored.
- Latency: START accepted at cycle t gives BUSY high t+1..t+1+NUM_CH*DIV and DONE at t+2+NUM_CH*DIV.
  - Bit k is driven on OUTPUT during cycles t+2+k*DIV .. t+1+(k+1)*DIV.
- Bit order:
  - OUTPUT presents INPUT[0] first.
  - The first D bit sampled lands in CFG[0]; the last lands in CFG[NUM_CH-1].
- CFG is never partially updated. It is glitch-free between commits.
- Widths:
  - div_cnt = max(1, clog2(DIV)).
  - bit_cnt = clog2(NUM_CH+1).
  - Both counters wrap only via explicit clear, never by overflow.
- INPUT changes after CAPTURE do not affect the transaction. D is ignored outside strobe cycles.

Decomposition:
- Shared package scan_frame_pkg:
  - state enum (IDLE, CAPTURE, SHIFT, FINISH);
  - mode constants MODE_CAPTURE=2'b00, MODE_LOAD=2'b01, MODE_XCHG=2'b10;
  - helper function for counter width.
- One natural sub-module: scan_bit_timer. It contains the divider plus bit counter, producing strobe and last_bit, with clear input.
- FSM and shift register stay in the top.

Test Plan:
- Reset values (NUM_CH=8, DIV=2, CFG_RESET=8'hA5): hold RESET 3 cycles, then release -> CFG=8'hA5, OUTPUT/BUSY/DONE/OUT_VALID=0.
- Capture (INPUT=8'b1100_1010, MODE=00, START pulse at t) -> OUTPUT bit sequence 0,1,0,1,0,0,1,1 each held 2 cycles, 8 OUT_VALID strobes, DONE at t+18, CFG unchanged 8'hA5.
- Load (MODE=01, D sequence 1,0,0,0,0,0,0,1 one per strobe) -> CFG=8'h81 exactly at the DONE cycle, CFG=8'hA5 one cycle earlier.
- Exchange (MODE=10, DIV=1 build, INPUT=8'hF0, D=8'h3C LSB-first) -> OUTPUT 0,0,0,0,1,1,1,1; CFG=8'h3C; DONE at t+10.
- Ignored START: START pulse in SHIFT and in FINISH, MODE toggled -> no second transaction, latched mode unchanged, exactly one DONE.
- Abort: RESET asserted mid-SHIFT after 3 bits of a load -> next cycle IDLE, CFG=CFG_RESET, no DONE. A new START after release completes normally.
